// File: rtl/pdp8_dbreak_arb_if.sv
// Signal bundle between the data-break arbiter, its I/O device channels and the
// single pdp8_io memory port. The arbiter takes the master view.
interface pdp8_dbreak_arb_if #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned MA_W = 15,
  parameter int unsigned D_W  = 12
);
  logic [NCH-1:0]      ch_read_req;
  logic [NCH-1:0]      ch_write_req;
  logic [NCH*MA_W-1:0] ch_ma;
  logic [NCH*D_W-1:0]  ch_wdata;
  logic [NCH-1:0]      ch_done;
  logic                ch_error;
  logic [D_W-1:0]      ch_rdata;
  logic [NCH-1:0]      err_status;
  logic [NCH-1:0]      err_clear;
  logic                io_ram_read_req;
  logic                io_ram_write_req;
  logic [MA_W-1:0]     io_ram_ma;
  logic [D_W-1:0]      io_ram_in;
  logic [D_W-1:0]      io_ram_out;
  logic                io_ram_done;

  modport master (
    input  ch_read_req, ch_write_req, ch_ma, ch_wdata, err_clear, io_ram_out, io_ram_done,
    output ch_done, ch_error, ch_rdata, err_status,
           io_ram_read_req, io_ram_write_req, io_ram_ma, io_ram_in
  );

  modport slave (
    output ch_read_req, ch_write_req, ch_ma, ch_wdata, err_clear, io_ram_out, io_ram_done,
    input  ch_done, ch_error, ch_rdata, err_status,
           io_ram_read_req, io_ram_write_req, io_ram_ma, io_ram_in
  );
endinterface

// File: rtl/pdp8_dbreak_arb.sv
// Round-robin data-break arbiter: grants one channel at a time onto the memory
// port, returns read data and aborts stalled cycles with a sticky error flag.
module pdp8_dbreak_arb #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned MA_W    = 15,
  parameter int unsigned D_W     = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  pdp8_dbreak_arb_if.master bus
);
  localparam int unsigned PTR_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] grant, grant_nxt;
  logic             is_wr, is_wr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rd_req, rd_req_nxt;
  logic             wr_req, wr_req_nxt;
  logic [MA_W-1:0]  ma, ma_nxt;
  logic [D_W-1:0]   wd, wd_nxt;
  logic [D_W-1:0]   rdata, rdata_nxt;
  logic [NCH-1:0]   done, done_nxt;
  logic             error, error_nxt;
  logic [NCH-1:0]   err, err_nxt, err_set;

  logic [NCH-1:0]   pending;
  logic             pick_vld;
  logic [PTR_W-1:0] pick;
  int unsigned      idx;
  logic             sel_wr;
  logic [MA_W-1:0]  sel_ma;
  logic [D_W-1:0]   sel_wd;

  assign pending = bus.ch_read_req | bus.ch_write_req;

  // First requester at or above rr_ptr (wrapping), plus that channel's payload.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!pick_vld && pending[PTR_W'(idx)]) begin
        pick_vld = 1'b1;
        pick     = PTR_W'(idx);
      end
    end
    sel_wr = 1'b0;
    sel_ma = '0;
    sel_wd = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (pick == PTR_W'(k)) begin
        sel_wr = bus.ch_write_req[k];
        sel_ma = bus.ch_ma[k*MA_W +: MA_W];
        sel_wd = bus.ch_wdata[k*D_W +: D_W];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    is_wr_nxt  = is_wr;
    cnt_nxt    = cnt;
    rd_req_nxt = rd_req;
    wr_req_nxt = wr_req;
    ma_nxt     = ma;
    wd_nxt     = wd;
    rdata_nxt  = rdata;
    done_nxt   = '0;
    error_nxt  = 1'b0;
    err_set    = '0;
    unique case (state)
      S_IDLE: begin
        if (pick_vld) begin
          grant_nxt  = pick;
          is_wr_nxt  = sel_wr;
          ma_nxt     = sel_ma;
          wd_nxt     = sel_wd;
          rd_req_nxt = !sel_wr;
          wr_req_nxt = sel_wr;
          cnt_nxt    = '0;
          rr_ptr_nxt = (32'(pick) + 32'd1 >= NCH) ? '0 : PTR_W'(32'(pick) + 32'd1);
          state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        cnt_nxt = cnt + 1'b1;
        // A completion on the final timeout cycle still counts as a good transfer.
        if (bus.io_ram_done) begin
          rd_req_nxt      = 1'b0;
          wr_req_nxt      = 1'b0;
          if (!is_wr) rdata_nxt = bus.io_ram_out;
          done_nxt[grant] = 1'b1;
          state_nxt       = S_DONE;
        end else if (TIMEOUT != 0 && cnt == CNT_W'(TO_LAST)) begin
          rd_req_nxt      = 1'b0;
          wr_req_nxt      = 1'b0;
          done_nxt[grant] = 1'b1;
          error_nxt       = 1'b1;
          err_set[grant]  = 1'b1;
          state_nxt       = S_DONE;
        end
      end
      S_DONE: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    err_nxt = (err & ~bus.err_clear) | err_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      is_wr  <= 1'b0;
      cnt    <= '0;
      rd_req <= 1'b0;
      wr_req <= 1'b0;
      ma     <= '0;
      wd     <= '0;
      rdata  <= '0;
      done   <= '0;
      error  <= 1'b0;
      err    <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
      is_wr  <= is_wr_nxt;
      cnt    <= cnt_nxt;
      rd_req <= rd_req_nxt;
      wr_req <= wr_req_nxt;
      ma     <= ma_nxt;
      wd     <= wd_nxt;
      rdata  <= rdata_nxt;
      done   <= done_nxt;
      error  <= error_nxt;
      err    <= err_nxt;
    end
  end

  assign bus.ch_done          = done;
  assign bus.ch_error         = error;
  assign bus.ch_rdata         = rdata;
  assign bus.err_status       = err;
  assign bus.io_ram_read_req  = rd_req;
  assign bus.io_ram_write_req = wr_req;
  assign bus.io_ram_ma        = ma;
  assign bus.io_ram_in        = wd;
endmodule
